// File: rtl/ram_1port_responder_if.sv
// rtl/ram_1port_responder_if.sv - command/response bundle for ram_1port_responder
// Optional o_Rsp_Addr member present only when RAM_RSP_ADDR_ECHO_EN is defined.
interface ram_1port_responder_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
);
  logic             i_Cmd_DV;
  logic             o_Cmd_Ready;
  logic             i_Cmd_Wr;
  logic [AW-1:0]    i_Cmd_Addr;
  logic [WIDTH-1:0] i_Cmd_Data;
  logic             o_Rsp_DV;
  logic             i_Rsp_Ready;
  logic [WIDTH-1:0] o_Rsp_Data;
`ifdef RAM_RSP_ADDR_ECHO_EN
  logic [AW-1:0]    o_Rsp_Addr;

  modport slave (
    input  i_Cmd_DV, i_Cmd_Wr, i_Cmd_Addr, i_Cmd_Data, i_Rsp_Ready,
    output o_Cmd_Ready, o_Rsp_DV, o_Rsp_Data, o_Rsp_Addr
  );
  modport master (
    output i_Cmd_DV, i_Cmd_Wr, i_Cmd_Addr, i_Cmd_Data, i_Rsp_Ready,
    input  o_Cmd_Ready, o_Rsp_DV, o_Rsp_Data, o_Rsp_Addr
  );
`else
  modport slave (
    input  i_Cmd_DV, i_Cmd_Wr, i_Cmd_Addr, i_Cmd_Data, i_Rsp_Ready,
    output o_Cmd_Ready, o_Rsp_DV, o_Rsp_Data
  );
  modport master (
    output i_Cmd_DV, i_Cmd_Wr, i_Cmd_Addr, i_Cmd_Data, i_Rsp_Ready,
    input  o_Cmd_Ready, o_Rsp_DV, o_Rsp_Data
  );
`endif
endinterface

// File: rtl/ram_1port_responder.sv
// rtl/ram_1port_responder.sv - single-port RAM target with flow-controlled read response FIFO
// Define RAM_RSP_ADDR_ECHO_EN to carry the read address alongside the data (o_Rsp_Addr).
module ram_1port_responder #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst,
  ram_1port_responder_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = $clog2(RSP_DEPTH);
  localparam int OW = $clog2(RSP_DEPTH + 1);

  logic [WIDTH-1:0] mem_q       [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [RSP_DEPTH];
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [OW-1:0]    fifo_cnt_q, fifo_cnt_d, outst_q, outst_d;
  logic             cmd_ready_q, rd_vld_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             cmd_fire, wr_fire, rd_fire, addr_ok, push, pop, rsp_dv;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign cmd_fire = bus.i_Cmd_DV & cmd_ready_q;
  assign wr_fire  = cmd_fire & bus.i_Cmd_Wr;
  assign rd_fire  = cmd_fire & ~bus.i_Cmd_Wr;
  assign addr_ok  = ({1'b0, bus.i_Cmd_Addr} < (AW + 1)'(DEPTH));
  assign rsp_dv   = (fifo_cnt_q != '0);
  assign push     = rd_vld_q;
  assign pop      = rsp_dv & bus.i_Rsp_Ready;

  // Outstanding covers the in-flight read as well as FIFO entries, so a push always has room.
  always_comb begin
    outst_d    = outst_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({rd_fire, pop})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + OW'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - OW'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      outst_q     <= '0;
      fifo_cnt_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      cmd_ready_q <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      outst_q     <= outst_d;
      fifo_cnt_q  <= fifo_cnt_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      cmd_ready_q <= (outst_d < OW'(RSP_DEPTH));
      rd_vld_q    <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= addr_ok ? mem_q[bus.i_Cmd_Addr] : '0;
      end
    end
  end

  // Array storage is deliberately left out of reset.
  always_ff @(posedge i_Clk) begin
    if (wr_fire && addr_ok) begin
      mem_q[bus.i_Cmd_Addr] <= bus.i_Cmd_Data;
    end
    if (push) begin
      fifo_data_q[tail_q] <= rd_data_q;
    end
  end

  assign bus.o_Cmd_Ready = cmd_ready_q;
  assign bus.o_Rsp_DV    = rsp_dv;
  assign bus.o_Rsp_Data  = rsp_dv ? fifo_data_q[head_q] : '0;

`ifdef RAM_RSP_ADDR_ECHO_EN
  logic [AW-1:0] rd_addr_q;
  logic [AW-1:0] fifo_addr_q [RSP_DEPTH];

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      rd_addr_q <= '0;
    end else if (rd_fire) begin
      rd_addr_q <= bus.i_Cmd_Addr;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (push) begin
      fifo_addr_q[tail_q] <= rd_addr_q;
    end
  end

  assign bus.o_Rsp_Addr = rsp_dv ? fifo_addr_q[head_q] : '0;
`endif
endmodule
